// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the block-copy memory master.
package mem_copy_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_copy_ctrl.sv
// Block-copy master for the single-port data memory.
//
// state | meaning
// IDLE  | CPU memory port passed straight through; waits for start
// READ  | drive source pointer, capture read byte into buffer
// WRITE | drive destination pointer, write buffered byte, step pointers
// DONE  | one-cycle completion pulse, memory port parked
//
// Overlapping regions are handled memmove-style: when the destination lies
// inside (src, src+len) the copy runs from the top byte downwards.
module mem_copy_ctrl
    import mem_copy_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          start,
    input  logic [AW-1:0] srcAddr,
    input  logic [AW-1:0] dstAddr,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    input  logic [AW-1:0] cpuAddr,
    input  logic [DW-1:0] cpuDataIn,
    input  logic          cpuMemOp,
    output logic          cpuStall,
    output logic [AW-1:0] memAddr,
    output logic [DW-1:0] memDataOut,
    output logic          memOp,
    input  logic [DW-1:0] memDataIn
);

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] buf_q, buf_d;
    logic          bwd_q, bwd_d;

    logic [AW-1:0] diff;
    logic [AW-1:0] len_m1;
    logic          go_bwd;

    // Direction decision on the raw request; modular difference catches wrap overlap.
    always_comb begin
        diff   = dstAddr - srcAddr;
        len_m1 = len - ONE;
        go_bwd = (diff != '0) && (diff < len);
    end

    // State and datapath registers; reset aborts any copy in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            bwd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            bwd_q   <= bwd_d;
        end
    end

    // Next-state, pointer stepping and memory port mux.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        bwd_d      = bwd_q;
        busy       = 1'b1;
        done       = 1'b0;
        memAddr    = '0;
        memDataOut = buf_q;
        memOp      = MEM_READ;

        unique case (state_q)
            IDLE: begin
                busy       = 1'b0;
                memAddr    = cpuAddr;
                memDataOut = cpuDataIn;
                memOp      = cpuMemOp;
                if (start) begin
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = len;
                        bwd_d   = go_bwd;
                        src_d   = go_bwd ? srcAddr + len_m1 : srcAddr;
                        dst_d   = go_bwd ? dstAddr + len_m1 : dstAddr;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                memAddr = src_q;
                memOp   = MEM_READ;
                buf_d   = memDataIn;
                state_d = WRITE;
            end
            WRITE: begin
                memAddr = dst_q;
                memOp   = MEM_WRITE;
                cnt_d   = cnt_q - ONE;
                src_d   = bwd_q ? src_q - ONE : src_q + ONE;
                dst_d   = bwd_q ? dst_q - ONE : dst_q + ONE;
                state_d = (cnt_q == ONE) ? DONE : READ;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cpuStall = busy;

endmodule
